// File: rtl/bpu_update_sched.sv
// bpu_update_sched: merges branch-resolution updates from two execute pipes
// into one in-order FIFO and drains it onto the predictor-table update port.
// After reset, a clear sweep visits every table index before any update drains.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   req0_* / req1_*   pipe update requests (req0 older), valid/ready handshake
//   upd_ready         tables can accept an update this cycle
//   upd_*             update strobe and head-entry payload
//   clr_en, clr_idx   clear strobe and index during the sweep
//   busy              high while the sweep runs
//   count             FIFO occupancy
// Optional: define BPU_UPD_STATS_EN to add stat_upd_cnt / stat_taken_cnt.
module bpu_update_sched #(
    parameter int DEPTH = 4,
    parameter int IDX_W = 6,
    parameter int PC_W  = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       req0_valid,
    input  logic [PC_W-1:0]            req0_pc,
    input  logic                       req0_taken,
    input  logic [PC_W-1:0]            req0_target,
    output logic                       req0_ready,
    input  logic                       req1_valid,
    input  logic [PC_W-1:0]            req1_pc,
    input  logic                       req1_taken,
    input  logic [PC_W-1:0]            req1_target,
    output logic                       req1_ready,
    input  logic                       upd_ready,
    output logic                       upd_en,
    output logic [PC_W-1:0]            upd_pc,
    output logic                       upd_taken,
    output logic [PC_W-1:0]            upd_target,
    output logic                       clr_en,
    output logic [IDX_W-1:0]           clr_idx,
    output logic                       busy,
    output logic [$clog2(DEPTH):0]     count
`ifdef BPU_UPD_STATS_EN
    ,
    output logic [31:0]                stat_upd_cnt,
    output logic [31:0]                stat_taken_cnt
`endif
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_C = CW'(DEPTH);
    localparam logic [CW-1:0] LIM2_C = CW'(DEPTH - 1);
    localparam logic [IDX_W-1:0] SWEEP_LAST = {IDX_W{1'b1}};

    typedef enum logic {
        S_INIT,
        S_RUN
    } state_t;

    typedef struct packed {
        logic [PC_W-1:0] pc;
        logic            taken;
        logic [PC_W-1:0] target;
    } entry_t;

    state_t           state_q;
    logic [IDX_W-1:0] sweep_q;
    entry_t           mem [DEPTH];
    logic [PW-1:0]    head_q;
    logic [PW-1:0]    tail_q;
    logic [CW-1:0]    count_q;

    logic          acc0;
    logic          acc1;
    logic          pop;
    logic [PW-1:0] wr1_ptr;
    entry_t        head_e;

    // Readiness uses the registered count only; a same-cycle pop
    // is deliberately not credited, so a push can never overflow.
    assign req0_ready = count_q < FULL_C;
    assign req1_ready = (count_q < LIM2_C)
                      | ((count_q < FULL_C) & ~req0_valid);

    assign acc0 = ~rst & req0_valid & req0_ready;
    assign acc1 = ~rst & req1_valid & req1_ready;
    assign pop  = ~rst & (state_q == S_RUN)
                & (count_q != '0) & upd_ready;

    // req1 lands behind req0 when both are taken in the same cycle.
    assign wr1_ptr = tail_q + PW'(acc0);

    assign head_e     = mem[head_q];
    assign upd_en     = pop;
    assign upd_pc     = rst ? '0 : head_e.pc;
    assign upd_taken  = ~rst & head_e.taken;
    assign upd_target = rst ? '0 : head_e.target;

    assign clr_en  = ~rst & (state_q == S_INIT);
    assign busy    = ~rst & (state_q == S_INIT);
    assign clr_idx = rst ? '0 : sweep_q;
    assign count   = rst ? '0 : count_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_INIT;
            sweep_q <= '0;
        end else begin
            unique case (state_q)
                S_INIT: begin
                    sweep_q <= sweep_q + 1'b1;
                    if (sweep_q == SWEEP_LAST) begin
                        state_q <= S_RUN;
                    end
                end
                S_RUN: begin
                    state_q <= S_RUN;
                end
                default: begin
                    state_q <= S_INIT;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_q + PW'(pop);
            tail_q  <= tail_q + PW'(acc0) + PW'(acc1);
            count_q <= count_q + CW'(acc0) + CW'(acc1) - CW'(pop);
        end
    end

    // Storage has no reset; occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (acc0) begin
            mem[tail_q] <= '{pc: req0_pc, taken: req0_taken,
                             target: req0_target};
        end
        if (acc1) begin
            mem[wr1_ptr] <= '{pc: req1_pc, taken: req1_taken,
                              target: req1_target};
        end
    end

`ifdef BPU_UPD_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_upd_cnt   <= '0;
            stat_taken_cnt <= '0;
        end else begin
            if (pop && stat_upd_cnt != 32'hFFFF_FFFF) begin
                stat_upd_cnt <= stat_upd_cnt + 32'd1;
            end
            if (pop && upd_taken
                && stat_taken_cnt != 32'hFFFF_FFFF) begin
                stat_taken_cnt <= stat_taken_cnt + 32'd1;
            end
        end
    end
`else
    // Statistics counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_bpu_update_sched.sv
// tb_bpu_update_sched: directed bench for bpu_update_sched
// (DEPTH=4, IDX_W=6, PC_W=32) with hand-computed expectations.
module tb_bpu_update_sched;

    logic        clk;
    logic        rst;
    logic        req0_valid;
    logic [31:0] req0_pc;
    logic        req0_taken;
    logic [31:0] req0_target;
    logic        req0_ready;
    logic        req1_valid;
    logic [31:0] req1_pc;
    logic        req1_taken;
    logic [31:0] req1_target;
    logic        req1_ready;
    logic        upd_ready;
    logic        upd_en;
    logic [31:0] upd_pc;
    logic        upd_taken;
    logic [31:0] upd_target;
    logic        clr_en;
    logic [5:0]  clr_idx;
    logic        busy;
    logic [2:0]  count;
`ifdef BPU_UPD_STATS_EN
    logic [31:0] stat_upd_cnt;
    logic [31:0] stat_taken_cnt;
`endif

    int n_checks = 0;
    int n_errors = 0;

    bpu_update_sched #(
        .DEPTH(4),
        .IDX_W(6),
        .PC_W (32)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_pc    (req0_pc),
        .req0_taken (req0_taken),
        .req0_target(req0_target),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_pc    (req1_pc),
        .req1_taken (req1_taken),
        .req1_target(req1_target),
        .req1_ready (req1_ready),
        .upd_ready  (upd_ready),
        .upd_en     (upd_en),
        .upd_pc     (upd_pc),
        .upd_taken  (upd_taken),
        .upd_target (upd_target),
        .clr_en     (clr_en),
        .clr_idx    (clr_idx),
        .busy       (busy),
        .count      (count)
`ifdef BPU_UPD_STATS_EN
        ,
        .stat_upd_cnt  (stat_upd_cnt),
        .stat_taken_cnt(stat_taken_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic drive0(input logic v, input logic [31:0] pc,
                          input logic tk, input logic [31:0] tg);
        req0_valid  = v;
        req0_pc     = pc;
        req0_taken  = tk;
        req0_target = tg;
    endtask

    task automatic drive1(input logic v, input logic [31:0] pc,
                          input logic tk, input logic [31:0] tg);
        req1_valid  = v;
        req1_pc     = pc;
        req1_taken  = tk;
        req1_target = tg;
    endtask

    task automatic idle();
        drive0(1'b0, 32'h0, 1'b0, 32'h0);
        drive1(1'b0, 32'h0, 1'b0, 32'h0);
    endtask

    task automatic expect_upd(input string tag, input logic [31:0] pc,
                              input logic tk, input logic [31:0] tg);
        check({tag, "_en"}, 64'(upd_en), 64'(1'b1));
        check({tag, "_pc"}, 64'(upd_pc), 64'(pc));
        check({tag, "_tk"}, 64'(upd_taken), 64'(tk));
        check({tag, "_tg"}, 64'(upd_target), 64'(tg));
    endtask

    logic [31:0] exp_pc [4];

    initial begin
        rst       = 1'b1;
        upd_ready = 1'b0;
        idle();
        tick();
        tick();

        // During reset every non-ready output is zero.
        check("rst_upd_en", 64'(upd_en), 64'(0));
        check("rst_clr_en", 64'(clr_en), 64'(0));
        check("rst_busy",   64'(busy),   64'(0));
        check("rst_count",  64'(count),  64'(0));
        check("rst_r0rdy",  64'(req0_ready), 64'(1));
        check("rst_r1rdy",  64'(req1_ready), 64'(1));

        // Clear sweep: 64 cycles, clr_idx 0..63.
        rst = 1'b0;
        for (int i = 0; i < 64; i++) begin
            settle();
            check("sweep_clr_en", 64'(clr_en), 64'(1));
            check("sweep_idx",    64'(clr_idx), 64'(i));
            check("sweep_busy",   64'(busy), 64'(1));
            tick();
        end
        settle();
        check("post_busy",   64'(busy),   64'(0));
        check("post_clr_en", 64'(clr_en), 64'(0));
        check("post_upd_en", 64'(upd_en), 64'(0));

        // Single update, one-cycle latency.
        upd_ready = 1'b1;
        drive0(1'b1, 32'h1C00_0010, 1'b1, 32'h1C00_0100);
        settle();
        check("single_r0rdy", 64'(req0_ready), 64'(1));
        check("single_noearly", 64'(upd_en), 64'(0));
        tick();
        idle();
        settle();
        expect_upd("single", 32'h1C00_0010, 1'b1, 32'h1C00_0100);
        check("single_cnt1", 64'(count), 64'(1));
        tick();
        settle();
        check("single_cnt0", 64'(count), 64'(0));
        check("single_idle", 64'(upd_en), 64'(0));

        // Dual push, req0 drains before req1.
        drive0(1'b1, 32'h100, 1'b0, 32'h500);
        drive1(1'b1, 32'h104, 1'b1, 32'h600);
        settle();
        check("dual_r0rdy", 64'(req0_ready), 64'(1));
        check("dual_r1rdy", 64'(req1_ready), 64'(1));
        tick();
        idle();
        settle();
        expect_upd("dual_a", 32'h100, 1'b0, 32'h500);
        check("dual_cnt2", 64'(count), 64'(2));
        tick();
        settle();
        expect_upd("dual_b", 32'h104, 1'b1, 32'h600);
        check("dual_cnt1", 64'(count), 64'(1));
        tick();
        settle();
        check("dual_cnt0", 64'(count), 64'(0));
        check("dual_idle", 64'(upd_en), 64'(0));

        // Fill under back-pressure.
        upd_ready = 1'b0;
        drive0(1'b1, 32'h200, 1'b1, 32'h1200);
        drive1(1'b1, 32'h204, 1'b0, 32'h1204);
        tick();
        drive0(1'b1, 32'h208, 1'b1, 32'h1208);
        drive1(1'b0, 32'h0, 1'b0, 32'h0);
        tick();
        drive0(1'b1, 32'h20C, 1'b0, 32'h120C);
        drive1(1'b1, 32'h210, 1'b1, 32'h1210);
        settle();
        check("c3_count",  64'(count), 64'(3));
        check("c3_r0rdy",  64'(req0_ready), 64'(1));
        check("c3_r1rdy",  64'(req1_ready), 64'(0));
        tick();
        settle();
        check("full_count", 64'(count), 64'(4));
        check("full_r0rdy", 64'(req0_ready), 64'(0));
        check("full_r1rdy", 64'(req1_ready), 64'(0));
        idle();
        tick();
        settle();
        check("hold_count", 64'(count), 64'(4));
        check("hold_upd_en", 64'(upd_en), 64'(0));

        exp_pc[0] = 32'h200;
        exp_pc[1] = 32'h204;
        exp_pc[2] = 32'h208;
        exp_pc[3] = 32'h20C;
        upd_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            settle();
            expect_upd("drain", exp_pc[i], ~exp_pc[i][2],
                       exp_pc[i] + 32'h1000);
            check("drain_cnt", 64'(count), 64'(4 - i));
            tick();
        end
        settle();
        check("drain_empty", 64'(count), 64'(0));
        check("drain_idle", 64'(upd_en), 64'(0));

        // Mid-operation reset with three entries queued.
        upd_ready = 1'b0;
        drive0(1'b1, 32'hDEAD_0000, 1'b1, 32'hDEAD_1000);
        drive1(1'b1, 32'hDEAD_0004, 1'b1, 32'hDEAD_1004);
        tick();
        drive1(1'b0, 32'h0, 1'b0, 32'h0);
        tick();
        idle();
        settle();
        check("mid_count3", 64'(count), 64'(3));
        rst = 1'b1;
        upd_ready = 1'b1;
        tick();
        settle();
        check("mrst_count",  64'(count),  64'(0));
        check("mrst_upd_en", 64'(upd_en), 64'(0));
        check("mrst_upd_pc", 64'(upd_pc), 64'(0));
        check("mrst_clr_en", 64'(clr_en), 64'(0));
        rst = 1'b0;

        // Sweep restarts; two entries pushed during INIT wait for RUN.
        for (int i = 0; i < 64; i++) begin
            if (i == 5) begin
                drive0(1'b1, 32'h300, 1'b1, 32'h700);
                drive1(1'b1, 32'h304, 1'b0, 32'h704);
            end
            settle();
            check("rsw_idx", 64'(clr_idx), 64'(i));
            check("rsw_busy", 64'(busy), 64'(1));
            check("rsw_upd_en", 64'(upd_en), 64'(0));
            if (i > 5) begin
                check("rsw_count", 64'(count), 64'(2));
            end
            tick();
            idle();
        end
        settle();
        check("init_busy", 64'(busy), 64'(0));
        expect_upd("init_a", 32'h300, 1'b1, 32'h700);
        tick();
        settle();
        expect_upd("init_b", 32'h304, 1'b0, 32'h704);
        tick();
        for (int i = 0; i < 3; i++) begin
            settle();
            check("nostale_en", 64'(upd_en), 64'(0));
            check("nostale_cnt", 64'(count), 64'(0));
            tick();
        end
`ifdef BPU_UPD_STATS_EN
        check("stat_upd",   64'(stat_upd_cnt),   64'(2));
        check("stat_taken", 64'(stat_taken_cnt), 64'(1));
`endif

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/bpu_update_sched.md
Name: bpu_update_sched

Overview:
- Schedules branch-resolution updates from two execute pipes onto the single update port of the branch predictor tables (BHT/BTB).
- Buffers updates in an in-order FIFO and drains at most one per cycle, gated by table readiness.
- After reset, a clear sweep initialises every table index before any update is released.

Parameters:
DEPTH, 4, FIFO entries (power of two, >=2)
IDX_W, 6, table index width; clear sweep covers 2^IDX_W indices
PC_W, 32, PC/target width

Ports:
clk  in  1  clock
rst  in  1  reset
req0_valid  in  1  pipe-0 update valid (older of the pair)
req0_pc  in  PC_W  pipe-0 branch PC
req0_taken  in  1  pipe-0 actual direction
req0_target  in  PC_W  pipe-0 actual target
req0_ready  out  1  pipe-0 accepted when valid&ready
req1_valid  in  1  pipe-1 update valid
req1_pc  in  PC_W  pipe-1 branch PC
req1_taken  in  1  pipe-1 actual direction
req1_target  in  PC_W  pipe-1 actual target
req1_ready  out  1  pipe-1 accepted when valid&ready
upd_ready  in  1  tables can take an update this cycle
upd_en  out  1  update strobe to tables
upd_pc  out  PC_W  update PC
upd_taken  out  1  update direction
upd_target  out  PC_W  update target
clr_en  out  1  clear strobe for table entry clr_idx
clr_idx  out  IDX_W  index being cleared
busy  out  1  high while clear sweep is running
count  out  $clog2(DEPTH)+1  FIFO occupancy

Behaviour:
- Reset: rst is synchronous, active-high. On rst: FIFO emptied (count=0, head/tail=0), state=INIT, sweep counter=0. While rst is high, all outputs are 0 except req0_ready/req1_ready.
- States: INIT, RUN.
  - INIT: clr_en=1, clr_idx=sweep counter, busy=1. Counter increments every cycle, regardless of upd_ready.
  - INIT->RUN: the cycle after clr_idx=2^IDX_W-1 is emitted. The sweep lasts exactly 2^IDX_W cycles.
  - RUN: clr_en=0, busy=0. No return to INIT except via rst.
- Push rules (both states):
  - free = DEPTH - count, using the registered count; a same-cycle pop is not credited.
  - req0_ready = (free>=1).
  - req1_ready = (free>=2) | (free>=1 & ~req0_valid).
  - When both are accepted in one cycle, req0 is written first (tail), then req1 (tail+1). tail advances by the number of accepted requests.
- Pop rules:
  - upd_en = (state==RUN) & (count!=0) & upd_ready. This is combinational.
  - upd_pc/taken/target are driven from the head entry at all times; they are meaningful only when upd_en=1.
  - When upd_en=1, head advances by 1.
- Latency: a request accepted in cycle N can produce upd_en no earlier than cycle N+1.
- Count update: count_next = count + pushes - pops, where pushes is 0..2 and pops is 0..1. Simultaneous push and pop are allowed. Push at full is impossible because the ready signals are derived from the pre-pop count.
- Pointers: wrap modulo DEPTH.
- Ordering: strict FIFO. Updates reach the tables in acceptance order, with req0 before req1 within a cycle.
- Back-pressure: upd_ready=0 holds the head entry and holds upd_en low. No entry is dropped.
- Updates accepted during INIT are buffered and begin draining in the first RUN cycle.

Optional Feature:
- Macro: BPU_UPD_STATS_EN.
- When defined, adds outputs stat_upd_cnt[31:0] and stat_taken_cnt[31:0].
  - stat_upd_cnt increments on every upd_en.
  - stat_taken_cnt increments on every upd_en with upd_taken=1.
  - Both counters saturate at 32'hFFFF_FFFF and are cleared by rst.
- When not defined, these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Reset sweep, IDX_W=6: deassert rst -> clr_en=1 for exactly 64 cycles, clr_idx 0..63, busy=1 throughout. The next cycle has busy=0 and clr_en=0.
- Single update in RUN, upd_ready=1: req0 pc=0x1C000010, taken=1, target=0x1C000100 in cycle N -> cycle N+1 has upd_en=1 with the same values; count returns to 0.
- Dual push with ordering: req0 pc=0x100 and req1 pc=0x104 in the same cycle, upd_ready=1 -> upd_en in two consecutive cycles, pc 0x100 then 0x104.
- Full/back-pressure: upd_ready=0, DEPTH=4, push 4 entries -> count=4, req0_ready=0, req1_ready=0. With count=3 and both valid -> req0_ready=1, req1_ready=0. Raising upd_ready -> the 4 entries drain in order, one per cycle.
- Buffering during INIT: push 2 entries during the sweep -> upd_en stays 0 until the first RUN cycle, then the 2 entries are emitted in order.
- Mid-operation reset: with count=3, pulse rst -> count=0, upd_en=0, sweep restarts at clr_idx=0, and no stale entries are emitted afterwards.
